md_engine: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage; next-generation replacement for the fixed 32-bit, fixed-latency multiply/divide block. Adds configurable operand width and per-class latencies, multiply-accumulate operations (MADD/MADDU/MSUB/MSUBU), a flush input that cancels an in-flight operation, and a `done` pulse. The hazard unit stalls D on `start | busy` for any instruction that touches HI/LO.

---
 rtl/md_pkg.sv | 36 +++
 rtl/md_arith.sv | 61 ++++++
 rtl/md_engine.sv | 109 ++++++++++
 tb/tb_md_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide engine: op codes, op-class
// decoders and FSM state encoding.
package md_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath: next {hi,lo} for multiply, multiply-accumulate and
// divide ops, including the divide-by-zero hold.
module md_arith #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   d1,
    input  logic [WIDTH-1:0]   d2,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] next_hilo
);
    import md_pkg::*;

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    logic               sgn_s;
    logic [2*WIDTH-1:0] a_s, b_s, prod_s, acc_s;
    logic [WIDTH-1:0]   num_mag_s, den_mag_s, den_safe_s;
    logic [WIDTH-1:0]   q_mag_s, r_mag_s, q_s, r_s;
    logic               div_zero_s;

    // Extension, product and sign-magnitude division; the truncated 2W
    // product of sign-extended operands is the exact two's complement result.
    always_comb begin
        sgn_s      = (op == OP_MULT) || (op == OP_MADD) ||
                     (op == OP_MSUB) || (op == OP_DIV);
        a_s        = sgn_s ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
        b_s        = sgn_s ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
        prod_s     = a_s * b_s;
        acc_s      = {hi, lo};
        num_mag_s  = (sgn_s && d1[WIDTH-1]) ? (~d1 + ONE_W) : d1;
        den_mag_s  = (sgn_s && d2[WIDTH-1]) ? (~d2 + ONE_W) : d2;
        div_zero_s = (d2 == {WIDTH{1'b0}});
        den_safe_s = div_zero_s ? ONE_W : den_mag_s;
        q_mag_s    = num_mag_s / den_safe_s;
        r_mag_s    = num_mag_s % den_safe_s;
        // -2^(W-1) / -1 falls out naturally: magnitude 2^(W-1) wraps back to itself
        q_s        = (sgn_s && (d1[WIDTH-1] ^ d2[WIDTH-1])) ? (~q_mag_s + ONE_W) : q_mag_s;
        r_s        = (sgn_s && d1[WIDTH-1]) ? (~r_mag_s + ONE_W) : r_mag_s;
    end

    // Result selection per op class
    always_comb begin
        next_hilo = acc_s;
        case (op)
            OP_MULT, OP_MULTU: next_hilo = prod_s;
            OP_MADD, OP_MADDU: next_hilo = acc_s + prod_s;
            OP_MSUB, OP_MSUBU: next_hilo = acc_s - prod_s;
            OP_DIV, OP_DIVU: begin
                if (div_zero_s) begin
                    next_hilo = acc_s;
                end else begin
                    next_hilo = {r_s, q_s};
                end
            end
            default: next_hilo = acc_s;
        endcase
    end

endmodule

// File: rtl/md_engine.sv
// Multi-cycle multiply/divide unit with HI/LO registers, configurable
// latencies, flush cancellation and a done pulse.
module md_engine #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import md_pkg::*;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_lat_chk
        $error("md_engine: MUL_LAT and DIV_LAT must both be at least 1");
    end

    md_state_t          state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] pend_r;
    logic [2*WIDTH-1:0] next_hilo_s;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op        (op),
        .d1        (d1),
        .d2        (d2),
        .hi        (hi_r),
        .lo        (lo_r),
        .next_hilo (next_hilo_s)
    );

    // FSM, latency counter, pending result and HI/LO; flush outranks both start and commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            pend_r  <= {(2*WIDTH){1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (flush) begin
                state_r <= ST_IDLE;
                cnt_r   <= {CNT_W{1'b0}};
                pend_r  <= {(2*WIDTH){1'b0}};
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start && is_mul(op)) begin
                            pend_r  <= next_hilo_s;
                            cnt_r   <= CNT_W'(MUL_LAT - 1);
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end else if (start && is_div(op)) begin
                            pend_r  <= next_hilo_s;
                            cnt_r   <= CNT_W'(DIV_LAT - 1);
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                        end else if (start && is_mt(op)) begin
                            if (op == OP_MTHI) begin
                                hi_r <= d1;
                            end else begin
                                lo_r <= d1;
                            end
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            {hi_r, lo_r} <= pend_r;
                            state_r      <= ST_IDLE;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_engine.sv
// Directed self-checking bench for md_engine (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
module tb_md_engine;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] d1 = 32'd0;
    logic [31:0] d2 = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    md_engine #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .d1    (d1),
        .d2    (d2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a start for one edge; returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; d1 = a; d2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE; d1 = 32'd0; d2 = 32'd0;
    endtask

    // Counts busy cycles (bounded) and ends at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int exp_busy);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        check_eq({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic saw_done;

        // Reset state
        #12;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // MULT -3 * 7 = -21
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check_eq("mult_busy_t0", 64'(busy), 64'd1);
        wait_done("mult", 5);
        check_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        @(negedge clk);
        check_eq("mult_done_once", 64'(done), 64'd0);

        // DIVU 100/7, then DIV -7/2 issued in the done cycle
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("divu", 10);
        check_eq("divu_lo", 64'(lo), 64'd14);
        check_eq("divu_hi", 64'(hi), 64'd2);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check_eq("b2b_busy", 64'(busy), 64'd1);
        wait_done("div_b2b", 10);
        check_eq("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        check_eq("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        @(negedge clk);

        // MTHI/MTLO then multiply-accumulate
        issue(OP_MTHI, 32'd5, 32'd0);
        check_eq("mthi_busy", 64'(busy), 64'd0);
        check_eq("mthi_hi", 64'(hi), 64'd5);
        issue(OP_MTLO, 32'd3, 32'd0);
        check_eq("mtlo_lo", 64'(lo), 64'd3);
        @(negedge clk);
        check_eq("mt_no_done", 64'(done), 64'd0);
        issue(OP_MADDU, 32'd2, 32'd4);
        wait_done("maddu", 5);
        check_eq("maddu_hi", 64'(hi), 64'd5);
        check_eq("maddu_lo", 64'(lo), 64'd11);
        issue(OP_MSUB, 32'd1, 32'd12);
        wait_done("msub", 5);
        check_eq("msub_hi", 64'(hi), 64'd4);
        check_eq("msub_lo", 64'(lo), 64'hFFFF_FFFF);
        @(negedge clk);

        // Divide by zero holds HI/LO; then the signed overflow case
        issue(OP_MTHI, 32'hA, 32'd0);
        issue(OP_MTLO, 32'hB, 32'd0);
        issue(OP_DIV, 32'd5, 32'd0);
        wait_done("divz", 10);
        check_eq("divz_hi", 64'(hi), 64'hA);
        check_eq("divz_lo", 64'(lo), 64'hB);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf", 10);
        check_eq("divovf_lo", 64'(lo), 64'h8000_0000);
        check_eq("divovf_hi", 64'(hi), 64'd0);
        @(negedge clk);

        // Flush in cycle 3 of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_eq("flush_no_done", 64'(saw_done), 64'd0);
        check_eq("flush_hi", 64'(hi), 64'd0);
        check_eq("flush_lo", 64'(lo), 64'h8000_0000);

        // Flush on the commit edge of a MULT
        issue(OP_MULT, 32'd3, 32'd3);
        repeat (5) @(negedge clk);
        check_eq("fce_busy_pre", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("fce_busy", 64'(busy), 64'd0);
        check_eq("fce_hi", 64'(hi), 64'd0);
        check_eq("fce_lo", 64'(lo), 64'h8000_0000);
        @(negedge clk);
        check_eq("fce_no_done", 64'(done), 64'd0);

        // Flush with a same-cycle MTLO
        start = 1'b1; op = OP_MTLO; d1 = 32'h1234; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE; d1 = 32'd0; flush = 1'b0;
        check_eq("flush_mtlo_lo", 64'(lo), 64'h8000_0000);
        @(negedge clk);

        // MTHI while busy is ignored
        issue(OP_MULTU, 32'd2, 32'd3);
        repeat (2) @(negedge clk);
        issue(OP_MTHI, 32'h77, 32'd0);
        check_eq("mthi_busy_ign", 64'(hi), 64'd0);
        wait_done("multu", 3);
        check_eq("multu_hi", 64'(hi), 64'd0);
        check_eq("multu_lo", 64'(lo), 64'd6);
        @(negedge clk);

        // Asynchronous reset mid-MULT
        issue(OP_MTHI, 32'h55, 32'd0);
        issue(OP_MULT, 32'd9, 32'd9);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_hi", 64'(hi), 64'd0);
        check_eq("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("arst_no_done", 64'(done), 64'd0);
        check_eq("arst_lo_after", 64'(lo), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
